// File: rtl/nfca_rx_tobytes_pkg.sv
// Shared ISO14443-A PICC receive definitions: FSM encodings, group geometry and parity sense.
// Kept in step with the PCD-side tx framer, which builds groups with the same rules.
package nfca_rx_tobytes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int   NFCA_BITS_PER_GROUP = 9;
  localparam logic NFCA_PARITY_ODD     = 1'b1;

  // Bit position of the parity bit inside a group; data occupies 0..PARITY_POS-1.
  localparam logic [3:0] PARITY_POS = 4'(NFCA_BITS_PER_GROUP - 1);

  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return (^{data, par}) == NFCA_PARITY_ODD;
  endfunction

endpackage

// File: rtl/nfca_rx_tobytes_if.sv
// Bit-stream input and byte/end-of-frame output bundle between the bit slicer side and the frame buffer.
// The slave modport is the byte collector; the master modport is whoever drives bits and consumes bytes.
interface nfca_rx_tobytes_if;

  logic       rx_on;
  logic       rx_bit_en;
  logic       rx_bit;
  logic       rx_end;
  logic       rx_end_col;
  logic       rx_end_err;
  logic       rx_byte_en;
  logic [7:0] rx_byte;
  logic       rx_tend;
  logic [2:0] rx_tbits;
  logic       rx_tend_col;
  logic       rx_tend_err;

  modport slave (
    input  rx_on, rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err,
    output rx_byte_en, rx_byte, rx_tend, rx_tbits, rx_tend_col, rx_tend_err
  );

  modport master (
    output rx_on, rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err,
    input  rx_byte_en, rx_byte, rx_tend, rx_tbits, rx_tend_col, rx_tend_err
  );

endinterface

// File: rtl/nfca_rx_tobytes.sv
// Packs the LSB-first PICC bit stream into 8+odd-parity groups, emits bytes and an end-of-frame report.
// All outputs registered, one cycle after the causing strobe; no backpressure, strobes are fire-and-forget.
module nfca_rx_tobytes
  import nfca_rx_tobytes_pkg::*;
#(
  parameter int MAX_BYTES = 64
) (
  input  logic               clk,
  input  logic               rstn,
  nfca_rx_tobytes_if.slave   rx
);

  localparam int              BCW       = $clog2(MAX_BYTES + 1);
  localparam logic [BCW-1:0]  BYTES_MAX = BCW'(MAX_BYTES);

  state_e          state_q, state_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic [BCW-1:0]  bytecnt_q, bytecnt_d;
  logic [7:0]      shreg_q, shreg_d;

  logic            byte_en_q, byte_en_d;
  logic [7:0]      byte_q, byte_d;
  logic            tend_q, tend_d;
  logic [2:0]      tbits_q, tbits_d;
  logic            tend_col_q, tend_col_d;
  logic            tend_err_q, tend_err_d;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    bytecnt_d  = bytecnt_q;
    shreg_d    = shreg_q;
    byte_en_d  = 1'b0;
    byte_d     = 8'h00;
    tend_d     = 1'b0;
    tbits_d    = 3'd0;
    tend_col_d = 1'b0;
    tend_err_d = 1'b0;

    if (!rx.rx_on) begin
      state_d   = ST_IDLE;
      bitcnt_d  = 4'd0;
      bytecnt_d = '0;
      shreg_d   = 8'h00;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RECV: begin
          if (rx.rx_end) begin
            // End wins over a coincident bit; any pending bits go out as a final byte.
            state_d    = ST_DONE;
            tend_d     = 1'b1;
            tend_col_d = rx.rx_end_col;
            tend_err_d = rx.rx_end_err;
            if (bitcnt_q != 4'd0) begin
              byte_en_d = 1'b1;
              byte_d    = shreg_q;
              if (bitcnt_q == PARITY_POS) begin
                tend_col_d = rx.rx_end_col;
                tend_err_d = !rx.rx_end_col;
              end else begin
                tbits_d = bitcnt_q[2:0];
              end
            end
          end else if (rx.rx_bit_en) begin
            if (bytecnt_q == BYTES_MAX) begin
              state_d    = ST_DONE;
              tend_d     = 1'b1;
              tend_err_d = 1'b1;
            end else if (bitcnt_q != PARITY_POS) begin
              state_d                 = ST_RECV;
              shreg_d[bitcnt_q[2:0]]  = rx.rx_bit;
              bitcnt_d                = bitcnt_q + 4'd1;
            end else if (parity_ok(shreg_q, rx.rx_bit)) begin
              // shreg is cleared so a later partial byte carries zeros above its last bit.
              byte_en_d = 1'b1;
              byte_d    = shreg_q;
              bitcnt_d  = 4'd0;
              shreg_d   = 8'h00;
              if (bytecnt_q != BYTES_MAX) bytecnt_d = bytecnt_q + BCW'(1);
            end else begin
              state_d    = ST_DONE;
              tend_d     = 1'b1;
              tend_err_d = 1'b1;
            end
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 4'd0;
      bytecnt_q  <= '0;
      shreg_q    <= 8'h00;
      byte_en_q  <= 1'b0;
      byte_q     <= 8'h00;
      tend_q     <= 1'b0;
      tbits_q    <= 3'd0;
      tend_col_q <= 1'b0;
      tend_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      bytecnt_q  <= bytecnt_d;
      shreg_q    <= shreg_d;
      byte_en_q  <= byte_en_d;
      byte_q     <= byte_d;
      tend_q     <= tend_d;
      tbits_q    <= tbits_d;
      tend_col_q <= tend_col_d;
      tend_err_q <= tend_err_d;
    end
  end

  assign rx.rx_byte_en  = byte_en_q;
  assign rx.rx_byte     = byte_q;
  assign rx.rx_tend     = tend_q;
  assign rx.rx_tbits    = tbits_q;
  assign rx.rx_tend_col = tend_col_q;
  assign rx.rx_tend_err = tend_err_q;

endmodule

// File: tb/tb_nfca_rx_tobytes.sv
// Bench for nfca_rx_tobytes: directed frames plus random frames against a queue-of-bits frame model.
module tb_nfca_rx_tobytes;

  localparam int MB = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  nfca_rx_tobytes_if rxi ();

  nfca_rx_tobytes #(.MAX_BYTES(MB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rxi)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit gaps    = 1'b0;

  // Reference: every data/parity bit of the current frame in arrival order.
  bit   mq[$];
  bit   mdone;
  logic       e_ben, e_tend, e_col, e_err;
  logic [7:0] e_byte;
  logic [2:0] e_tbits;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit on, input bit ben, input bit b, input bit en,
                       input bit ecol, input bit eerr);
    int sz, rem, ones;
    e_ben = 0; e_byte = 0; e_tend = 0; e_tbits = 0; e_col = 0; e_err = 0;
    if (!on) begin
      mq.delete();
      mdone = 0;
    end else if (mdone) begin
      mdone = 1;
    end else if (en) begin
      sz  = mq.size();
      rem = sz % 9;
      e_tend = 1; e_col = ecol; e_err = eerr; mdone = 1;
      if (rem > 0) begin
        e_ben = 1;
        for (int i = 0; i < rem && i < 8; i++) e_byte[i] = mq[sz - rem + i];
        if (rem == 8) begin
          e_tbits = 0; e_col = ecol; e_err = !ecol;
        end else begin
          e_tbits = 3'(rem);
        end
      end
    end else if (ben) begin
      if (mq.size() == 9 * MB) begin
        e_tend = 1; e_err = 1; mdone = 1;
      end else begin
        mq.push_back(b);
        sz = mq.size();
        if (sz % 9 == 0) begin
          ones = 0;
          for (int i = 0; i < 9; i++) ones += int'(mq[sz - 9 + i]);
          if (ones % 2 == 1) begin
            e_ben = 1;
            for (int i = 0; i < 8; i++) e_byte[i] = mq[sz - 9 + i];
          end else begin
            e_tend = 1; e_err = 1; mdone = 1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("byte_en",  32'(rxi.rx_byte_en),  32'(e_ben));
    chk("byte",     32'(rxi.rx_byte),     32'(e_byte));
    chk("tend",     32'(rxi.rx_tend),     32'(e_tend));
    chk("tbits",    32'(rxi.rx_tbits),    32'(e_tbits));
    chk("tend_col", 32'(rxi.rx_tend_col), 32'(e_col));
    chk("tend_err", 32'(rxi.rx_tend_err), 32'(e_err));
  endtask

  task automatic cyc(input bit on, input bit ben, input bit b, input bit en,
                     input bit ecol, input bit eerr);
    rxi.rx_on = on; rxi.rx_bit_en = ben; rxi.rx_bit = b;
    rxi.rx_end = en; rxi.rx_end_col = ecol; rxi.rx_end_err = eerr;
    model(on, ben, b, en, ecol, eerr);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send_bit(input bit b);
    cyc(1, 1, b, 0, 0, 0);
    if (gaps) repeat ($urandom_range(0, 1)) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit good);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(good ? ~^v : ^v);
  endtask

  task automatic end_frame(input bit col, input bit err);
    cyc(1, 0, 0, 1, col, err);
  endtask

  task automatic rx_off();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_reset();
    #2;
    rxi.rx_on = 0; rxi.rx_bit_en = 0; rxi.rx_bit = 0;
    rxi.rx_end = 0; rxi.rx_end_col = 0; rxi.rx_end_err = 0;
    rstn = 1'b0;
    mq.delete(); mdone = 0;
    e_ben = 0; e_byte = 0; e_tend = 0; e_tbits = 0; e_col = 0; e_err = 0;
    #1;
    check_outputs();
    #3;
    rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    int nbytes, trail;
    rxi.rx_on = 0; rxi.rx_bit_en = 0; rxi.rx_bit = 0;
    rxi.rx_end = 0; rxi.rx_end_col = 0; rxi.rx_end_err = 0;
    mdone = 0;
    e_ben = 0; e_byte = 0; e_tend = 0; e_tbits = 0; e_col = 0; e_err = 0;
    #1;
    check_outputs();
    #21;
    rstn = 1'b1;

    // Clean single byte then end.
    rx_off(); send_byte(8'h93, 1); end_frame(0, 0);
    // Bad parity: error end, trailing bits ignored.
    rx_off(); send_byte(8'hA5, 0); send_bit(1); send_bit(0); end_frame(0, 0);
    // Full byte then 3-bit partial with collision.
    rx_off(); send_byte(8'h3C, 1); send_bit(1); send_bit(0); send_bit(1); end_frame(1, 0);
    // Length overrun at MB bytes, then DONE holds.
    rx_off(); send_byte(8'h11, 1); send_byte(8'hFE, 1); send_bit(0);
    send_bit(1); end_frame(1, 1); cyc(1, 0, 0, 0, 0, 0);
    // Abort after 5 bits (with a coincident strobe), then a clean frame.
    rx_off(); for (int i = 0; i < 5; i++) send_bit(1'b1);
    cyc(0, 1, 1, 0, 0, 0); send_byte(8'h26, 1); end_frame(0, 0);
    // Bit and end together with nothing received.
    rx_off(); cyc(1, 1, 1, 1, 0, 0);
    // Parity missing at end, with and without collision.
    rx_off(); v = 8'hC3; for (int i = 0; i < 8; i++) send_bit(v[i]); end_frame(0, 0);
    rx_off(); v = 8'h7E; for (int i = 0; i < 8; i++) send_bit(v[i]); end_frame(1, 1);
    // Async reset while a byte strobe is showing, and mid-byte.
    rx_off(); send_byte(8'h5A, 1); async_reset();
    rx_off(); send_bit(1); send_bit(1); send_bit(0); async_reset();
    rx_off(); send_byte(8'h26, 1); end_frame(0, 0);

    gaps = 1'b1;
    repeat (150) begin
      rx_off();
      nbytes = $urandom_range(0, 3);
      for (int k = 0; k < nbytes; k++) send_byte(8'($urandom), $urandom_range(0, 19) != 0);
      trail = $urandom_range(0, 8);
      for (int k = 0; k < trail; k++) send_bit(1'($urandom));
      if ($urandom_range(0, 15) == 0) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      cyc(1, $urandom_range(0, 3) == 0, 1'($urandom), 1, 1'($urandom), 1'($urandom));
      send_bit(1'($urandom)); send_bit(1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
